// File: rtl/lcd_pkg.sv
// Shared definitions for the memory-mapped HD44780 LCD register: FSM states,
// register bit positions and the phase-timer width/load helper.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } lcd_state_e;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_REQ_BIT  = 30;
  localparam int LCD_BLON_BIT = 29;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_DATA_LSB = 0;

  localparam int TIMER_W = 17;

  // A phase of n cycles loads n-1; a zero-length phase still lasts one cycle.
  function automatic logic [TIMER_W-1:0] cyc_load(input int n);
    if (n <= 1) return '0;
    return TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter used to time each bus phase; o_zero marks the last
// cycle of the current phase.
module lcd_timer
  import lcd_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_value,
  output logic               o_zero
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// Turns each REQ toggle of the LCD register into one timed HD44780 write cycle
// and reports completion through the ack toggle and busy flag.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 1,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_LONG_CYC  = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic        o_lcd_busy,
  output logic        o_lcd_ack,
  output logic        o_lcd_on,
  output logic        o_lcd_blon,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output lcd_state_e  o_dbg_state
);

  // Request/ack protocol: a request is pending while REQ differs from ack and
  // ON is set; completion (or abort) makes ack equal REQ on the same edge.
  lcd_state_e         state_q, state_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic               long_q, long_d;
  logic               ack_q, ack_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_zero;

  logic on, req;
  assign on  = i_lcd_word[LCD_ON_BIT];
  assign req = i_lcd_word[LCD_REQ_BIT];

  logic unused_word_bits;
  assign unused_word_bits = ^{i_lcd_word[28:10], i_lcd_word[8]};

  lcd_timer u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (tmr_load),
    .i_value (tmr_value),
    .o_zero  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    data_d    = data_q;
    long_d    = long_q;
    ack_d     = ack_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      IDLE: begin
        if (!on) begin
          ack_d = req;
        end else if (req != ack_q) begin
          rs_d      = i_lcd_word[LCD_RS_BIT];
          data_d    = i_lcd_word[LCD_DATA_LSB +: 8];
          long_d    = !rs_d && (data_d[7:2] == 6'd0) && (data_d != 8'd0);
          state_d   = SETUP;
          tmr_load  = 1'b1;
          tmr_value = cyc_load(T_SETUP_CYC);
        end
      end
      SETUP: if (tmr_zero) begin
        state_d   = PULSE;
        tmr_load  = 1'b1;
        tmr_value = cyc_load(T_EN_CYC);
      end
      PULSE: if (tmr_zero) begin
        state_d   = HOLD;
        tmr_load  = 1'b1;
        tmr_value = cyc_load(T_HOLD_CYC);
      end
      HOLD: if (tmr_zero) begin
        state_d   = WAIT;
        tmr_load  = 1'b1;
        tmr_value = long_q ? cyc_load(T_LONG_CYC) : cyc_load(T_EXEC_CYC);
      end
      WAIT: if (tmr_zero) begin
        state_d = IDLE;
        ack_d   = ~ack_q;
      end
      default: state_d = IDLE;
    endcase
    // Power-off aborts any phase; ack absorbs the request so nothing replays.
    if (state_q != IDLE && !on) begin
      state_d  = IDLE;
      ack_d    = req;
      tmr_load = 1'b0;
    end
    en_d   = (state_d == PULSE);
    busy_d = (state_d != IDLE) || (on && (req != ack_d));
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      rs_q    <= 1'b0;
      data_q  <= 8'd0;
      long_q  <= 1'b0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign o_lcd_busy  = busy_q;
  assign o_lcd_ack   = ack_q;
  assign o_lcd_on    = on;
  assign o_lcd_blon  = i_lcd_word[LCD_BLON_BIT];
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_data  = data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl: a scoreboard queue holds the
// expected bus cycle for every request and is drained by a bus monitor.
module tb_lcd_hd44780_ctrl;
  import lcd_pkg::*;

  localparam int W      = 33;  // {rise_cyc[15:0], ack_delta[7:0], rs, data[7:0]}
  localparam int T_EN   = 12;
  localparam int T_EXEC = 20;
  localparam int T_LONG = 50;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [31:0] i_lcd_word = '0;
  logic        o_lcd_busy, o_lcd_ack, o_lcd_on, o_lcd_blon;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en;
  logic [7:0]  o_lcd_data;
  lcd_state_e  o_dbg_state;

  lcd_hd44780_ctrl #(.T_EXEC_CYC(T_EXEC), .T_LONG_CYC(T_LONG)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_lcd_word  (i_lcd_word),
    .o_lcd_busy  (o_lcd_busy),
    .o_lcd_ack   (o_lcd_ack),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_blon  (o_lcd_blon),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_data  (o_lcd_data),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         req_bit = 1'b0;

  function automatic logic [31:0] mk_word(input logic on, input logic req, input logic blon,
                                          input logic rs, input logic [7:0] d);
    logic [31:0] w;
    w = '0;
    w[31] = on; w[30] = req; w[29] = blon; w[9] = rs; w[7:0] = d;
    return w;
  endfunction

  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d >= 8'd1) && (d <= 8'd3);
  endfunction

  task automatic push_exp(input int rise, input int ackd, input logic rs, input logic [7:0] d);
    exp_q.push_back({rise[15:0], ackd[7:0], rs, d});
  endtask

  // Called at posedge+#1 with the controller idle; returns the write cycle.
  task automatic xfer(input logic rs, input logic [7:0] d, output int c);
    c = cyc;
    req_bit = ~req_bit;
    i_lcd_word = mk_word(1'b1, req_bit, 1'b0, rs, d);
    push_exp(c + 3, 1 + (is_long(rs, d) ? T_LONG : T_EXEC), rs, d);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (2) begin @(posedge clk); #1; end
    while (o_lcd_busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", {31'd0, o_lcd_busy}, 32'd0);
  endtask

  // ---------------- bus monitor ----------------
  int           en_rises = 0;
  int           rise_cyc, fall_cyc;
  logic         en_prev = 1'b0, ack_prev = 1'b0, in_xfer = 1'b0;
  logic [W-1:0] cur;

  always @(negedge clk) begin
    if (!i_reset) begin
      en_prev  = 1'b0;
      ack_prev = 1'b0;
      in_xfer  = 1'b0;
    end else begin
      if (o_lcd_en && !en_prev) begin
        en_rises++;
        check("exp_avail", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          rise_cyc = cyc;
          in_xfer  = 1'b1;
          check("rise_cyc", cyc, {16'd0, cur[32:17]});
          check("rs_at_en", {31'd0, o_lcd_rs}, {31'd0, cur[8]});
          check("data_at_en", {24'd0, o_lcd_data}, {24'd0, cur[7:0]});
        end
      end
      if (!o_lcd_en && en_prev && in_xfer) begin
        fall_cyc = cyc;
        check("en_width", cyc - rise_cyc, T_EN);
        check("rs_hold", {31'd0, o_lcd_rs}, {31'd0, cur[8]});
        check("data_hold", {24'd0, o_lcd_data}, {24'd0, cur[7:0]});
      end
      if (o_lcd_ack != ack_prev && in_xfer) begin
        check("ack_lat", cyc - fall_cyc, {24'd0, cur[16:9]});
        in_xfer = 1'b0;
      end
      en_prev  = o_lcd_en;
      ack_prev = o_lcd_ack;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int c, n0;
    logic [7:0] clr_tbl [6];
    logic       rs_r;
    logic [7:0] d_r;
    clr_tbl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h38, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    check("rst_en", {31'd0, o_lcd_en}, 32'd0);
    check("rst_busy", {31'd0, o_lcd_busy}, 32'd0);
    check("rst_ack", {31'd0, o_lcd_ack}, 32'd0);
    check("rst_data", {24'd0, o_lcd_data}, 32'd0);
    check("rst_state", {29'd0, o_dbg_state}, {29'd0, IDLE});
    i_reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Data write RS=1, 'A'
    xfer(1'b1, 8'h41, c);
    check("word_0141", i_lcd_word, 32'hC000_0241);
    @(posedge clk); #1;
    check("busy_rise", {31'd0, o_lcd_busy}, 32'd1);
    check("rw_zero", {31'd0, o_lcd_rw}, 32'd0);
    wait_idle(200);
    check("ack_after_41", {31'd0, o_lcd_ack}, {31'd0, req_bit});

    // Clear/home vs normal commands, then random bytes
    foreach (clr_tbl[i]) begin
      xfer(1'b0, clr_tbl[i], c);
      wait_idle(200);
      check("ack_cmd", {31'd0, o_lcd_ack}, {31'd0, req_bit});
    end
    xfer(1'b1, 8'h01, c);
    wait_idle(200);
    for (int i = 0; i < 6; i++) begin
      rs_r = 1'($urandom_range(0, 1));
      d_r  = 8'($urandom_range(0, 255));
      xfer(rs_r, d_r, c);
      wait_idle(200);
      check("ack_rand", {31'd0, o_lcd_ack}, {31'd0, req_bit});
    end

    // One flip during busy: queued, starts one cycle after ack
    xfer(1'b1, 8'h41, c);
    wait_cyc(c + 5);
    req_bit = ~req_bit;
    i_lcd_word = mk_word(1'b1, req_bit, 1'b0, 1'b1, 8'h42);
    push_exp(c + 39, 1 + T_EXEC, 1'b1, 8'h42);
    @(posedge clk); #1;
    check("bus_hold", {24'd0, o_lcd_data}, 32'h41);
    wait_idle(300);
    check("ack_b2b", {31'd0, o_lcd_ack}, {31'd0, req_bit});

    // Two flips during busy: nothing extra
    n0 = en_rises;
    xfer(1'b0, 8'h38, c);
    wait_cyc(c + 4);
    req_bit = ~req_bit;
    i_lcd_word = mk_word(1'b1, req_bit, 1'b0, 1'b0, 8'h38);
    wait_cyc(c + 6);
    req_bit = ~req_bit;
    i_lcd_word = mk_word(1'b1, req_bit, 1'b0, 1'b0, 8'h38);
    wait_idle(200);
    repeat (10) begin @(posedge clk); #1; end
    check("two_flip_en", en_rises, n0 + 1);
    check("two_flip_busy", {31'd0, o_lcd_busy}, 32'd0);

    // Abort by clearing ON during WAIT
    n0 = en_rises;
    c = cyc;
    req_bit = ~req_bit;
    i_lcd_word = mk_word(1'b1, req_bit, 1'b0, 1'b1, 8'h61);
    push_exp(c + 3, 6, 1'b1, 8'h61);
    wait_cyc(c + 20);
    i_lcd_word = mk_word(1'b0, req_bit, 1'b0, 1'b1, 8'h61);
    @(posedge clk); #1;
    check("abort_state", {29'd0, o_dbg_state}, {29'd0, IDLE});
    check("abort_busy", {31'd0, o_lcd_busy}, 32'd0);
    check("abort_ack", {31'd0, o_lcd_ack}, {31'd0, req_bit});
    check("abort_en", {31'd0, o_lcd_en}, 32'd0);
    repeat (30) begin @(posedge clk); #1; end
    check("abort_no_extra", en_rises, n0 + 1);

    // ON=0: requests ignored, ack tracks REQ; power-up replays nothing
    n0 = en_rises;
    i_lcd_word = mk_word(1'b0, req_bit, 1'b1, 1'b0, 8'h00);
    #1;
    check("on_comb", {31'd0, o_lcd_on}, 32'd0);
    check("blon_comb", {31'd0, o_lcd_blon}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      req_bit = ~req_bit;
      i_lcd_word = mk_word(1'b0, req_bit, 1'b0, 1'b1, 8'h55);
      @(posedge clk); #1;
      check("off_ack_track", {31'd0, o_lcd_ack}, {31'd0, req_bit});
    end
    repeat (100) begin @(posedge clk); #1; end
    check("off_no_en", en_rises, n0);
    check("off_busy", {31'd0, o_lcd_busy}, 32'd0);
    i_lcd_word = mk_word(1'b1, req_bit, 1'b0, 1'b1, 8'h55);
    #1;
    check("on_comb_hi", {31'd0, o_lcd_on}, 32'd1);
    repeat (30) begin @(posedge clk); #1; end
    check("powerup_no_en", en_rises, n0);
    check("powerup_busy", {31'd0, o_lcd_busy}, 32'd0);

    // Async reset mid-PULSE
    xfer(1'b1, 8'h55, c);
    wait_cyc(c + 8);
    check("pre_rst_en", {31'd0, o_lcd_en}, 32'd1);
    i_reset = 1'b0;
    #1;
    check("rst_mid_en", {31'd0, o_lcd_en}, 32'd0);
    check("rst_mid_busy", {31'd0, o_lcd_busy}, 32'd0);
    i_lcd_word = '0;
    req_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("post_rst_ack", {31'd0, o_lcd_ack}, 32'd0);
    check("post_rst_data", {24'd0, o_lcd_data}, 32'd0);
    check("post_rst_busy", {31'd0, o_lcd_busy}, 32'd0);
    check("post_rst_en", {31'd0, o_lcd_en}, 32'd0);

    // Recovery after reset
    xfer(1'b1, 8'h7A, c);
    wait_idle(200);
    check("recover_ack", {31'd0, o_lcd_ack}, {31'd0, req_bit});
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
